// File: rtl/tx_link_fault_rs_if.sv
// Bus bundle for tx_link_fault_rs: fault status, MAC TX column in, XGMII TX column out.
// TX_LF_STATS_EN adds the rf_col_cnt / drain_abort_cnt statistics signals.
interface tx_link_fault_rs_if;
  logic [1:0]  link_fault;
  logic [31:0] mac_txd;
  logic [3:0]  mac_txc;
  logic [31:0] xgmii_txd;
  logic [3:0]  xgmii_txc;
  logic        mac_tx_hold;
  logic        fault_active;
`ifdef TX_LF_STATS_EN
  logic [31:0] rf_col_cnt;
  logic [15:0] drain_abort_cnt;
`endif

  modport master (
    output link_fault, mac_txd, mac_txc,
    input  xgmii_txd, xgmii_txc, mac_tx_hold, fault_active
`ifdef TX_LF_STATS_EN
    , input rf_col_cnt, drain_abort_cnt
`endif
  );

  modport slave (
    input  link_fault, mac_txd, mac_txc,
    output xgmii_txd, xgmii_txc, mac_tx_hold, fault_active
`ifdef TX_LF_STATS_EN
    , output rf_col_cnt, drain_abort_cnt
`endif
  );
endinterface

// File: rtl/tx_link_fault_rs.sv
// TX reconciliation response to link-fault status: pass-through, drain, Remote Fault or Idle override.
// Optional statistics counters are enabled by defining TX_LF_STATS_EN.
module tx_link_fault_rs #(
  parameter int unsigned CLEAR_CYCLES = 128,
  parameter int unsigned DRAIN_MAX    = 2048
) (
  input  logic              rxclk_2x,
  input  logic              reset,
  tx_link_fault_rs_if.slave bus
);

  localparam int unsigned DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  localparam logic [31:0]   IDLE_D     = 32'h07070707;
  localparam logic [3:0]    IDLE_C     = 4'hF;
  localparam logic [31:0]   RF_D       = 32'h0200009C;
  localparam logic [3:0]    RF_C       = 4'b0001;
  localparam logic [7:0]    CLR_LAST   = 8'(CLEAR_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    ST_PASS,
    ST_DRAIN,
    ST_SEND_RF,
    ST_SEND_IDLE
  } state_t;

  typedef enum logic [1:0] {
    WANT_NONE,
    WANT_RF,
    WANT_IDLE
  } want_t;

  state_t        state_q, state_d;
  want_t         want;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]    clr_cnt_q, clr_cnt_d;
  logic          in_frame_q, in_frame_d;
  logic [31:0]   txd_q, txd_d;
  logic [3:0]    txc_q, txc_d;
  logic          fault_active_q;
  logic          start_col, term_col, col_open;

  function automatic state_t send_state(input want_t w);
    return (w == WANT_RF) ? ST_SEND_RF : ST_SEND_IDLE;
  endfunction

  // Local fault (bit 1) dominates, so 11 behaves as local.
  always_comb begin
    if (bus.link_fault[1])      want = WANT_RF;
    else if (bus.link_fault[0]) want = WANT_IDLE;
    else                        want = WANT_NONE;
  end

  always_comb begin
    logic [31:0] sh_d;
    logic [3:0]  sh_c;
    start_col = bus.mac_txc[0] && (bus.mac_txd[7:0] == 8'hFB);
    term_col  = 1'b0;
    sh_d      = bus.mac_txd;
    sh_c      = bus.mac_txc;
    for (int unsigned n = 0; n < 4; n++) begin
      if (sh_c[0] && ((sh_d[7:0] == 8'hFD) || (sh_d[7:0] == 8'hFE)))
        term_col = 1'b1;
      sh_d = sh_d >> 8;
      sh_c = sh_c >> 1;
    end
    // Terminate wins over Start in the same column.
    col_open = term_col ? 1'b0 : (start_col ? 1'b1 : in_frame_q);
  end

  // The PASS drain decision uses the frame state including the current column,
  // so a Start or Terminate arriving together with the fault is accounted for.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    clr_cnt_d   = clr_cnt_q;
    in_frame_d  = in_frame_q;
    txd_d       = bus.mac_txd;
    txc_d       = bus.mac_txc;

    unique case (state_q)
      ST_PASS: begin
        in_frame_d = col_open;
        clr_cnt_d  = '0;
        if (want != WANT_NONE)
          state_d = col_open ? ST_DRAIN : send_state(want);
      end

      ST_DRAIN: begin
        in_frame_d = col_open;
        clr_cnt_d  = '0;
        if (want == WANT_NONE)
          state_d = ST_PASS;
        else if (term_col || (drain_cnt_q == DRAIN_LAST))
          state_d = send_state(want);
        else
          drain_cnt_d = drain_cnt_q + DW'(1);
      end

      ST_SEND_RF, ST_SEND_IDLE: begin
        if (state_q == ST_SEND_RF) begin
          txd_d = RF_D;
          txc_d = RF_C;
        end else begin
          txd_d = IDLE_D;
          txc_d = IDLE_C;
        end
        if (want != WANT_NONE) begin
          clr_cnt_d = '0;
          state_d   = send_state(want);
        end else if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d  = '0;
          in_frame_d = 1'b0;
          state_d    = ST_PASS;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge rxclk_2x or posedge reset) begin
    if (reset) begin
      state_q        <= ST_PASS;
      drain_cnt_q    <= '0;
      clr_cnt_q      <= '0;
      in_frame_q     <= 1'b0;
      txd_q          <= IDLE_D;
      txc_q          <= IDLE_C;
      fault_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      in_frame_q     <= in_frame_d;
      txd_q          <= txd_d;
      txc_q          <= txc_d;
      fault_active_q <= (state_q == ST_SEND_RF) || (state_q == ST_SEND_IDLE);
    end
  end

  // Hold follows the next state so it rises with the fault and drops on the releasing cycle.
  assign bus.mac_tx_hold  = ~reset & (state_d != ST_PASS);
  assign bus.xgmii_txd    = txd_q;
  assign bus.xgmii_txc    = txc_q;
  assign bus.fault_active = fault_active_q;

`ifdef TX_LF_STATS_EN
  logic [31:0] rf_col_cnt_q;
  logic [15:0] drain_abort_cnt_q;
  logic        forced_exit;

  assign forced_exit = (state_q == ST_DRAIN) && (want != WANT_NONE) &&
                       !term_col && (drain_cnt_q == DRAIN_LAST);

  always_ff @(posedge rxclk_2x or posedge reset) begin
    if (reset) begin
      rf_col_cnt_q      <= '0;
      drain_abort_cnt_q <= '0;
    end else begin
      if ((state_q == ST_SEND_RF) && (rf_col_cnt_q != '1))
        rf_col_cnt_q <= rf_col_cnt_q + 32'd1;
      if (forced_exit && (drain_abort_cnt_q != '1))
        drain_abort_cnt_q <= drain_abort_cnt_q + 16'd1;
    end
  end

  assign bus.rf_col_cnt      = rf_col_cnt_q;
  assign bus.drain_abort_cnt = drain_abort_cnt_q;
`endif

endmodule

// File: tb/tb_tx_link_fault_rs.sv
// Self-checking bench for tx_link_fault_rs: vector table, directed corner sequences, random traffic vs model.
module tb_tx_link_fault_rs;

  localparam int unsigned CLEAR_CYCLES = 128;
  localparam int unsigned DRAIN_MAX    = 2048;
  localparam logic [31:0] IDLE_D = 32'h07070707;
  localparam logic [3:0]  IDLE_C = 4'hF;
  localparam logic [31:0] RF_D   = 32'h0200009C;
  localparam logic [3:0]  RF_C   = 4'b0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_link_fault_rs_if bus_if ();

  tx_link_fault_rs #(
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .DRAIN_MAX   (DRAIN_MAX)
  ) dut (
    .rxclk_2x(clk),
    .reset   (rst),
    .bus     (bus_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural reference: tracks whether we are overriding, waiting for a frame
  // to end, how long we have waited and how long the link has been quiet.
  bit          m_over, m_kind_rf, m_wait, m_open, m_fa, m_hold;
  int unsigned m_age, m_quiet;
  logic [31:0] m_txd;
  logic [3:0]  m_txc;
  longint      m_rf_cols;
  int unsigned m_aborts;

  function automatic void model_reset();
    m_over = 0; m_kind_rf = 0; m_wait = 0; m_open = 0; m_fa = 0; m_hold = 0;
    m_age = 0; m_quiet = 0; m_txd = IDLE_D; m_txc = IDLE_C;
    m_rf_cols = 0; m_aborts = 0;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] d, input int n);
    return 8'((d >> (8 * n)) & 32'hFF);
  endfunction

  function automatic void model_step(input logic [1:0] lf, input logic [31:0] d, input logic [3:0] c);
    bit quiet_in, rf_in, st, tm, after;
    quiet_in = (lf == 2'b00);
    rf_in    = lf[1];
    st       = c[0] && (lane_byte(d, 0) == 8'hFB);
    tm       = 0;
    for (int n = 0; n < 4; n++)
      if (c[n] && (lane_byte(d, n) == 8'hFD || lane_byte(d, n) == 8'hFE)) tm = 1;
    after = tm ? 1'b0 : (st ? 1'b1 : m_open);

    if (m_over) begin
      m_txd = m_kind_rf ? RF_D : IDLE_D;
      m_txc = m_kind_rf ? RF_C : IDLE_C;
      m_fa  = 1;
      if (m_kind_rf && m_rf_cols < 64'hFFFF_FFFF) m_rf_cols++;
      if (!quiet_in) begin
        m_quiet = 0; m_kind_rf = rf_in; m_hold = 1;
      end else if (m_quiet == CLEAR_CYCLES - 1) begin
        m_over = 0; m_quiet = 0; m_open = 0; m_hold = 0;
      end else begin
        m_quiet++; m_hold = 1;
      end
    end else begin
      m_txd  = d;
      m_txc  = c;
      m_fa   = 0;
      m_open = after;
      if (quiet_in) begin
        m_wait = 0; m_hold = 0;
      end else if (!m_wait) begin
        m_hold = 1;
        if (after) begin
          m_wait = 1; m_age = 0;
        end else begin
          m_over = 1; m_kind_rf = rf_in; m_quiet = 0;
        end
      end else if (tm || m_age == DRAIN_MAX - 1) begin
        if (!tm && m_aborts < 16'hFFFF) m_aborts++;
        m_wait = 0; m_over = 1; m_kind_rf = rf_in; m_quiet = 0; m_hold = 1;
      end else begin
        m_age++; m_hold = 1;
      end
    end
  endfunction

  // Drive inputs, then at the falling edge compare registered outputs and hold.
  task automatic apply(input logic [1:0] lf, input logic [31:0] d, input logic [3:0] c);
    bus_if.link_fault = lf;
    bus_if.mac_txd    = d;
    bus_if.mac_txc    = c;
    @(negedge clk);
    check("model_txd", bus_if.xgmii_txd, m_txd);
    check("model_txc", 32'(bus_if.xgmii_txc), 32'(m_txc));
    check("model_fa", 32'(bus_if.fault_active), 32'(m_fa));
`ifdef TX_LF_STATS_EN
    check("model_rf_cnt", bus_if.rf_col_cnt, m_rf_cols[31:0]);
    check("model_abort_cnt", 32'(bus_if.drain_abort_cnt), m_aborts);
`endif
    model_step(lf, d, c);
    check("model_hold", 32'(bus_if.mac_tx_hold), 32'(m_hold));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] lf, input logic [31:0] d, input logic [3:0] c);
    apply(lf, d, c);
    finish_cycle();
  endtask

  typedef struct packed {
    logic [1:0]  lf;
    logic [31:0] d;
    logic [3:0]  c;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic        eh;
    logic        efa;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] lf, input logic [31:0] d, input logic [3:0] c,
                              input logic [31:0] ed, input logic [3:0] ec, input logic eh, input logic efa);
    vec_t v;
    v.lf = lf; v.d = d; v.c = c; v.ed = ed; v.ec = ec; v.eh = eh; v.efa = efa;
    tbl.push_back(v);
  endfunction

  function automatic void build_table();
    logic [31:0] pd, d;
    logic [3:0]  pc, c;
    logic [7:0]  k;
    pd = IDLE_D; pc = IDLE_C;
    // Idle, Start, preamble, 16 data columns (64 bytes), Terminate, Idle: echoed one cycle later.
    for (int j = 0; j < 21; j++) begin
      if (j == 0 || j == 20)  begin d = IDLE_D;        c = IDLE_C;  end
      else if (j == 1)        begin d = 32'h555555FB;  c = 4'b0001; end
      else if (j == 2)        begin d = 32'hD5555555;  c = 4'b0000; end
      else if (j == 19)       begin d = 32'h070707FD;  c = 4'hF;    end
      else begin k = 8'(8'h10 + j); d = {4{k}}; c = 4'b0000; end
      add(2'b00, d, c, pd, pc, 1'b0, 1'b0);
      pd = d; pc = c;
    end
    // Local fault while idle, then remote, then both.
    add(2'b10, IDLE_D,       IDLE_C, IDLE_D, IDLE_C, 1'b1, 1'b0);
    add(2'b10, 32'hA5A5A5A5, 4'h0,   IDLE_D, IDLE_C, 1'b1, 1'b0);
    add(2'b10, 32'hA5A5A5A5, 4'h0,   RF_D,   RF_C,   1'b1, 1'b1);
    add(2'b10, 32'hA5A5A5A5, 4'h0,   RF_D,   RF_C,   1'b1, 1'b1);
    add(2'b01, 32'hA5A5A5A5, 4'h0,   RF_D,   RF_C,   1'b1, 1'b1);
    add(2'b01, 32'hA5A5A5A5, 4'h0,   RF_D,   RF_C,   1'b1, 1'b1);
    add(2'b01, 32'hA5A5A5A5, 4'h0,   IDLE_D, IDLE_C, 1'b1, 1'b1);
    add(2'b11, 32'hA5A5A5A5, 4'h0,   IDLE_D, IDLE_C, 1'b1, 1'b1);
    add(2'b11, 32'hA5A5A5A5, 4'h0,   IDLE_D, IDLE_C, 1'b1, 1'b1);
    add(2'b11, 32'hA5A5A5A5, 4'h0,   RF_D,   RF_C,   1'b1, 1'b1);
    add(2'b11, 32'hA5A5A5A5, 4'h0,   RF_D,   RF_C,   1'b1, 1'b1);
  endfunction

  task automatic test_clear_glitch();
    for (int i = 0; i < 127; i++) begin
      apply(2'b00, IDLE_D, IDLE_C);
      if (i == 126) check("clr1_hold_last", 32'(bus_if.mac_tx_hold), 32'd1);
      finish_cycle();
    end
    step(2'b01, IDLE_D, IDLE_C);
    for (int i = 0; i < 128; i++) begin
      apply(2'b00, IDLE_D, IDLE_C);
      if (i == 126) check("clr2_hold_126", 32'(bus_if.mac_tx_hold), 32'd1);
      if (i == 127) check("clr2_hold_127", 32'(bus_if.mac_tx_hold), 32'd0);
      finish_cycle();
    end
    apply(2'b00, IDLE_D, IDLE_C);
    check("clr_last_override_fa", 32'(bus_if.fault_active), 32'd1);
    finish_cycle();
    apply(2'b00, IDLE_D, IDLE_C);
    check("clr_pass_fa", 32'(bus_if.fault_active), 32'd0);
    finish_cycle();
  endtask

  task automatic test_drain_terminate();
    step(2'b00, 32'h555555FB, 4'b0001);
    step(2'b00, 32'hD5555555, 4'b0000);
    step(2'b00, 32'h11111111, 4'b0000);
    step(2'b00, 32'h22222222, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      apply(2'b01, 32'h30303030 + 32'(i), 4'b0000);
      check("drain_hold", 32'(bus_if.mac_tx_hold), 32'd1);
      finish_cycle();
    end
    step(2'b01, 32'h07FD3322, 4'b1100);
    apply(2'b01, 32'hDEADBEEF, 4'b0000);
    check("drain_term_passed_d", bus_if.xgmii_txd, 32'h07FD3322);
    check("drain_term_passed_c", 32'(bus_if.xgmii_txc), 32'h0000000C);
    finish_cycle();
    apply(2'b01, 32'hDEADBEEF, 4'b0000);
    check("drain_then_idle_d", bus_if.xgmii_txd, IDLE_D);
    check("drain_then_idle_fa", 32'(bus_if.fault_active), 32'd1);
    finish_cycle();
    for (int i = 0; i < 3; i++) step(2'b01, 32'hDEADBEEF, 4'b0000);
    for (int i = 0; i < CLEAR_CYCLES + 2; i++) step(2'b00, IDLE_D, IDLE_C);
  endtask

  task automatic test_drain_timeout();
    bit          seen;
    int unsigned first;
    seen = 0; first = 0;
    step(2'b00, 32'h555555FB, 4'b0001);
    step(2'b00, 32'hD5555555, 4'b0000);
    step(2'b00, 32'h44444444, 4'b0000);
    for (int unsigned k = 0; k < DRAIN_MAX + 10 && !seen; k++) begin
      step(2'b10, 32'h3C3C3C3C ^ k, 4'b0000);
      if (bus_if.fault_active === 1'b1) begin
        seen  = 1;
        first = k + 1;
      end
    end
    check("drain_timeout_first_rf_step", first, DRAIN_MAX + 2);
    check("drain_timeout_rf_d", bus_if.xgmii_txd, RF_D);
`ifdef TX_LF_STATS_EN
    check("drain_abort_cnt_one", 32'(bus_if.drain_abort_cnt), 32'd1);
`endif
    for (int i = 0; i < 3; i++) step(2'b10, IDLE_D, IDLE_C);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #2;
    check("rst_txd", bus_if.xgmii_txd, IDLE_D);
    check("rst_txc", 32'(bus_if.xgmii_txc), 32'(IDLE_C));
    check("rst_hold", 32'(bus_if.mac_tx_hold), 32'd0);
    check("rst_fa", 32'(bus_if.fault_active), 32'd0);
`ifdef TX_LF_STATS_EN
    check("rst_rf_cnt", bus_if.rf_col_cnt, 32'd0);
    check("rst_abort_cnt", 32'(bus_if.drain_abort_cnt), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_random(input int unsigned ncyc);
    int unsigned seg_left, frame_left, r, p;
    logic [1:0]  lf;
    logic [31:0] d;
    logic [3:0]  c;
    logic [7:0]  b;
    seg_left = 0; frame_left = 0; lf = 2'b00;
    for (int unsigned i = 0; i < ncyc; i++) begin
      if (seg_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 5)      begin lf = 2'b00; seg_left = $urandom_range(1, 200); end
        else if (r < 7) begin lf = 2'b10; seg_left = $urandom_range(1, 40);  end
        else if (r < 9) begin lf = 2'b01; seg_left = $urandom_range(1, 40);  end
        else            begin lf = 2'b11; seg_left = $urandom_range(1, 40);  end
      end
      seg_left--;
      if (frame_left == 0) begin
        r = $urandom_range(0, 19);
        if (r < 2) begin
          d = {$urandom_range(0, 255) & 32'h00FFFFFF} << 8 | 32'hFB; c = 4'b0001;
          frame_left = $urandom_range(2, 30);
        end else if (r == 2) begin
          d = 32'h07FD55FB; c = 4'b1101;
        end else begin
          d = IDLE_D; c = IDLE_C;
        end
      end else if (frame_left == 1) begin
        p = $urandom_range(0, 3);
        d = '0; c = '0;
        for (int n = 0; n < 4; n++) begin
          if (n < p) b = 8'($urandom);
          else if (n == p) begin
            b = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'hFD;
            c = c | 4'(1 << n);
          end else begin
            b = 8'h07;
            c = c | 4'(1 << n);
          end
          d = d | (32'(b) << (8 * n));
        end
        frame_left = 0;
      end else begin
        d = $urandom; c = 4'b0000;
        frame_left--;
      end
      step(lf, d, c);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.link_fault = 2'b00;
    bus_if.mac_txd    = IDLE_D;
    bus_if.mac_txc    = IDLE_C;
    model_reset();
    build_table();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].lf, tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d_txd", i), bus_if.xgmii_txd, tbl[i].ed);
      check($sformatf("vec%0d_txc", i), 32'(bus_if.xgmii_txc), 32'(tbl[i].ec));
      check($sformatf("vec%0d_hold", i), 32'(bus_if.mac_tx_hold), 32'(tbl[i].eh));
      check($sformatf("vec%0d_fa", i), 32'(bus_if.fault_active), 32'(tbl[i].efa));
      finish_cycle();
    end

    test_clear_glitch();
    test_drain_terminate();
    test_drain_timeout();
    test_reset_mid();
    run_random(6000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
